// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/XOR/CMP, bit-serial LSL/LSR, shift-add MUL.
// One operation per start/ready handshake; results are registered and held until the next completion.
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CMD_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic             flag,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [CMD_W-1:0] OP_ADD = CMD_W'(3'b000);
  localparam logic [CMD_W-1:0] OP_LSL = CMD_W'(3'b001);
  localparam logic [CMD_W-1:0] OP_MUL = CMD_W'(3'b010);
  localparam logic [CMD_W-1:0] OP_XOR = CMD_W'(3'b011);
  localparam logic [CMD_W-1:0] OP_LSR = CMD_W'(3'b101);
  localparam logic [CMD_W-1:0] OP_SUB = CMD_W'(3'b110);
  localparam logic [CMD_W-1:0] OP_CMP = CMD_W'(3'b111);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CMD_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rslt_q, rslt_d;
  logic               flag_q, flag_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               fin;
  logic [WIDTH-1:0]   res;
  logic               res_flag;
  logic               sh_left;
  logic [WIDTH-1:0]   sh_src;
  logic [WIDTH-1:0]   sh_val;
  logic               sh_out;
  logic [CNT_W-1:0]   shift_n;
  logic [ACC_W-1:0]   mul_sum;

  // Ready is a decode of the state so it rises in the first cycle after reset drops.
  assign ready = (state_q == S_IDLE) && !reset;
  assign done  = done_q;
  assign rslt  = rslt_q;
  assign flag  = flag_q;
  assign zero  = zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      work_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rslt_q   <= '0;
      flag_q   <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      work_q   <= work_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rslt_q   <= rslt_d;
      flag_q   <= flag_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    work_d   = work_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rslt_d   = rslt_q;
    flag_d   = flag_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    res      = '0;
    res_flag = 1'b0;

    // One shared single-bit shifter: fed from the operand on accept, from work_q while busy.
    sh_left = (state_q == S_IDLE) ? (alu_cmd == OP_LSL) : (op_q == OP_LSL);
    sh_src  = (state_q == S_IDLE) ? inA : work_q;
    sh_val  = sh_left ? (sh_src << 1) : (sh_src >> 1);
    sh_out  = sh_left ? sh_src[WIDTH-1] : sh_src[0];
    shift_n = (inB >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(inB);
    mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE: begin
        if (start && ready) begin
          op_d = alu_cmd;
          case (alu_cmd)
            OP_ADD: begin
              {res_flag, res} = {1'b0, inA} + {1'b0, inB};
              fin = 1'b1;
            end
            OP_SUB: begin
              res      = inA - inB;
              res_flag = (inA < inB);
              fin      = 1'b1;
            end
            OP_XOR: begin
              res = inA ^ inB;
              fin = 1'b1;
            end
            OP_CMP: begin
              res_flag = (inA == inB);
              fin      = 1'b1;
            end
            OP_LSL, OP_LSR: begin
              // First bit moves on the accept edge; remaining n-1 bits run in BUSY.
              if (shift_n == '0) begin
                res = inA;
                fin = 1'b1;
              end else if (shift_n == CNT_W'(1)) begin
                res      = sh_val;
                res_flag = sh_out;
                fin      = 1'b1;
              end else begin
                work_d  = sh_val;
                cnt_d   = shift_n - CNT_W'(1);
                state_d = S_BUSY;
              end
            end
            OP_MUL: begin
              acc_d    = inB[0] ? ACC_W'(inA) : '0;
              mcand_d  = ACC_W'(inA) << 1;
              mplier_d = inB >> 1;
              cnt_d    = CNT_W'(WIDTH - 1);
              state_d  = S_BUSY;
            end
            default: fin = 1'b1;
          endcase
        end
      end
      S_BUSY: begin
        if (op_q == OP_MUL) begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          res      = mul_sum[WIDTH-1:0];
          res_flag = |mul_sum[ACC_W-1:WIDTH];
        end else begin
          work_d   = sh_val;
          res      = sh_val;
          res_flag = sh_out;
        end
        if (cnt_q == CNT_W'(1)) begin
          fin = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      rslt_d  = res;
      flag_d  = res_flag;
      zero_d  = (res == '0);
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed test-plan steps followed by random
// operations checked cycle by cycle against an arithmetic reference model.
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         ready;
  logic         done;
  logic [W-1:0] rslt;
  logic         flag;
  logic         zero;

  int checks = 0;
  int errors = 0;
  int prev_r = 0;
  int prev_f = 0;
  int prev_z = 1;

  seq_alu #(.WIDTH(W), .CMD_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_cmd(alu_cmd),
    .inA(inA), .inB(inB), .ready(ready), .done(done),
    .rslt(rslt), .flag(flag), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the opcode definitions using integer arithmetic.
  function automatic void model(input logic [2:0] c, input int a, input int b,
                                output int r, output int f, output int lat);
    int n;
    n   = (b > W) ? W : b;
    r   = 0;
    f   = 0;
    lat = 1;
    case (c)
      3'b000: begin r = (a + b) & MASK; f = ((a + b) >> W) & 1; end
      3'b110: begin r = (a - b) & MASK; f = (a < b) ? 1 : 0; end
      3'b011: begin r = a ^ b; end
      3'b111: begin f = (a == b) ? 1 : 0; end
      3'b001: begin
        r   = (a << n) & MASK;
        f   = (n == 0) ? 0 : ((a >> (W - n)) & 1);
        lat = (n == 0) ? 1 : n;
      end
      3'b101: begin
        r   = a >> n;
        f   = (n == 0) ? 0 : ((a >> (n - 1)) & 1);
        lat = (n == 0) ? 1 : n;
      end
      3'b010: begin r = (a * b) & MASK; f = ((a * b) >> W) != 0 ? 1 : 0; lat = W; end
      default: begin end
    endcase
  endfunction

  // Called at a negedge with the DUT expected idle; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] c, input int a, input int b, input bit junk);
    int er, ef, lat;
    model(c, a, b, er, ef, lat);
    chk("ready_before_accept", 32'(ready), 32'd1);
    start   = 1'b1;
    alu_cmd = c;
    inA     = W'(a);
    inB     = W'(b);
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("done_op%0d_k%0d", c, k), 32'(done), 32'(k == lat));
      chk($sformatf("ready_op%0d_k%0d", c, k), 32'(ready), 32'(k == lat));
      if (k < lat) begin
        chk($sformatf("hold_rslt_op%0d_k%0d", c, k), 32'(rslt), 32'(prev_r));
        start   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        alu_cmd = 3'($urandom);
        inA     = W'($urandom);
        inB     = W'($urandom);
      end else begin
        chk($sformatf("rslt_op%0d_a%0h_b%0h", c, a, b), 32'(rslt), 32'(er));
        chk($sformatf("flag_op%0d_a%0h_b%0h", c, a, b), 32'(flag), 32'(ef));
        chk($sformatf("zero_op%0d_a%0h_b%0h", c, a, b), 32'(zero), 32'(er == 0));
        prev_r = er;
        prev_f = ef;
        prev_z = (er == 0) ? 1 : 0;
        start  = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag, input int exp_ready);
    chk({tag, "_rslt"}, 32'(rslt), 32'd0);
    chk({tag, "_flag"}, 32'(flag), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'(exp_ready));
  endtask

  initial begin
    logic [2:0] c;
    int a, b;
    reset   = 1'b1;
    start   = 1'b0;
    alu_cmd = '0;
    inA     = '0;
    inB     = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset", 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready), 32'd1);

    // Directed steps from the test plan, back-to-back where the plan asks for it.
    run_op(3'b000, 200, 100, 1'b0);
    run_op(3'b110, 5, 7, 1'b0);
    run_op(3'b111, 8'h5A, 8'h5A, 1'b0);
    run_op(3'b011, 8'hFF, 8'h0F, 1'b0);
    run_op(3'b001, 8'h20, 3, 1'b1);
    run_op(3'b101, 8'h81, 1, 1'b0);
    run_op(3'b001, 8'h01, 9, 1'b1);
    run_op(3'b101, 8'h80, 0, 1'b0);
    run_op(3'b010, 16, 17, 1'b1);
    run_op(3'b010, 15, 17, 1'b0);
    run_op(3'b100, 8'h33, 8'h44, 1'b0);
    run_op(3'b001, 8'hC3, 8, 1'b0);
    run_op(3'b101, 8'hC3, 8'hFF, 1'b0);
    run_op(3'b010, 255, 255, 1'b0);

    // Reset during a MUL: no done pulse, outputs cleared, ready back after reset drops.
    start   = 1'b1;
    alu_cmd = 3'b010;
    inA     = 8'd200;
    inB     = 8'd3;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("abort_done_k%0d", k), 32'(done), 32'd0);
      chk($sformatf("abort_ready_k%0d", k), 32'(ready), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort", 0);
    reset = 1'b0;
    prev_r = 0;
    prev_f = 0;
    prev_z = 1;
    @(negedge clk);
    check_reset_outputs("post_abort", 1);
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_no_done", 32'(done), 32'd0);
    end
    run_op(3'b000, 1, 2, 1'b0);

    // Random operations with random idle gaps and ignored starts while busy.
    for (int i = 0; i < 300; i++) begin
      c = 3'($urandom);
      a = int'($urandom_range(0, MASK));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MASK))
                                      : int'($urandom_range(0, W + 1));
      run_op(c, a, b, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_hold_rslt", 32'(rslt), 32'(prev_r));
        chk("idle_hold_flag", 32'(flag), 32'(prev_f));
        chk("idle_hold_zero", 32'(zero), 32'(prev_z));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
